// File: rtl/pll_video_rst_seq_pkg.sv
// Shared definitions for the video PLL reset/lock sequencer: state encoding
// and the status codes exposed on the state readback port.
package pll_video_rst_seq_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  // Status-register view of the same codes, for software readback decoding
  localparam logic [STATE_W-1:0] CODE_RESET     = 3'd0;
  localparam logic [STATE_W-1:0] CODE_WAIT_LOCK = 3'd1;
  localparam logic [STATE_W-1:0] CODE_STABLE    = 3'd2;
  localparam logic [STATE_W-1:0] CODE_RUN       = 3'd3;
  localparam logic [STATE_W-1:0] CODE_FAULT     = 3'd4;

endpackage

// File: rtl/pll_video_rst_seq_if.sv
// Control/status bundle between the sequencer and its surroundings:
// PLL lock input, restart request, PLL/video resets and status.
interface pll_video_rst_seq_if;
  import pll_video_rst_seq_pkg::*;

  logic               pll_locked;
  logic               restart;
  logic               pll_rst;
  logic               video_rst_n;
  logic               ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;
  logic [STATE_W-1:0] state;

  // Side that drives lock/restart and observes the sequencer
  modport master (
    output pll_locked, restart,
    input  pll_rst, video_rst_n, ready, fault, retry_cnt, state
  );

  // The sequencer itself
  modport slave (
    input  pll_locked, restart,
    output pll_rst, video_rst_n, ready, fault, retry_cnt, state
  );
endinterface

// File: rtl/pll_video_rst_seq_sync_2ff.sv
// Single-bit two-stage synchronizer with asynchronous active-low reset.
// Used to bring the PLL lock indication into the reference clock domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  // Two back-to-back flops give metastability a full cycle to settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_video_rst_seq.sv
// Reset/lock sequencer for the video PLL. Pulses the PLL reset, waits for a
// stable lock window, then releases the video-domain reset. Handles lock
// timeout with bounded retries, lock loss in RUN and software restart.
module pll_video_rst_seq
  import pll_video_rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 20
) (
  input logic               refclk,
  input logic               rst_n,
  pll_video_rst_seq_if.slave ctl
);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  state_e             state_reg, state_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic               lk;
  logic               pll_rst_reg;
  logic               video_rst_n_reg;
  logic               ready_reg;
  logic               fault_reg;

  sync_2ff lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (ctl.pll_locked),
    .q     (lk)
  );

  // Next-state and retry bookkeeping; restart overrides every other transition
  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    if (ctl.restart) begin
      state_next = ST_RESET;
      retry_next = '0;
    end else begin
      case (state_reg)
        ST_RESET: begin
          if (cnt_reg == RST_LAST) state_next = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lk) begin
            state_next = ST_STABLE;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            if (retry_reg < RETRY_MAX) begin
              retry_next = retry_reg + RETRY_W'(1);
              state_next = ST_RESET;
            end else begin
              state_next = ST_FAULT;
            end
          end
        end
        ST_STABLE: begin
          if (!lk) begin
            state_next = ST_WAIT_LOCK;
          end else if (cnt_reg == STABLE_LAST) begin
            state_next = ST_RUN;
            retry_next = '0;
          end
        end
        ST_RUN: begin
          if (!lk) state_next = ST_RESET;
        end
        ST_FAULT: state_next = ST_FAULT;
        default:  state_next = ST_RESET;
      endcase
    end
  end

  // State register; outputs are decoded from the next state so they change
  // on the same edge as the state and never glitch
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_RESET;
      retry_reg       <= '0;
      pll_rst_reg     <= 1'b1;
      video_rst_n_reg <= 1'b0;
      ready_reg       <= 1'b0;
      fault_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      retry_reg       <= retry_next;
      pll_rst_reg     <= (state_next == ST_RESET) || (state_next == ST_FAULT);
      video_rst_n_reg <= (state_next == ST_RUN);
      ready_reg       <= (state_next == ST_RUN);
      fault_reg       <= (state_next == ST_FAULT);
    end
  end

  // Shared cycle counter: cleared on any state change or restart, saturates
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (ctl.restart || (state_next != state_reg)) begin
      cnt_reg <= '0;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign ctl.pll_rst     = pll_rst_reg;
  assign ctl.video_rst_n = video_rst_n_reg;
  assign ctl.ready       = ready_reg;
  assign ctl.fault       = fault_reg;
  assign ctl.retry_cnt   = retry_reg;
  assign ctl.state       = state_reg;

endmodule

// File: tb/tb_pll_video_rst_seq.sv
// Bench for the video PLL reset sequencer: directed scenarios plus random
// lock/restart activity, all checked every cycle against a behavioural model.
module tb_pll_video_rst_seq;

  localparam int P_RST     = 4;
  localparam int P_STABLE  = 8;
  localparam int P_TMO     = 64;
  localparam int P_RETRIES = 2;

  localparam int S_RESET = 0, S_WAIT = 1, S_STABLE = 2, S_RUN = 3, S_FAULT = 4;

  logic refclk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 refclk = ~refclk;

  pll_video_rst_seq_if dif ();

  pll_video_rst_seq #(
    .PLL_RST_CYCLES      (P_RST),
    .LOCK_STABLE_CYCLES  (P_STABLE),
    .LOCK_TIMEOUT_CYCLES (P_TMO),
    .MAX_RETRIES         (P_RETRIES),
    .CNT_W               (20)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .ctl    (dif)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural reference: phase name, time spent in the phase, timeouts
  // seen, and the two-cycle delay the lock indication takes to be seen.
  int m_phase;
  int m_elapsed;
  int m_retries;
  bit m_lock_seen;
  bit m_lock_dly[2];

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase     = S_RESET;
      m_elapsed   = 0;
      m_retries   = 0;
      m_lock_dly  = '{1'b0, 1'b0};
    end else begin
      m_lock_seen   = m_lock_dly[1];
      m_lock_dly[1] = m_lock_dly[0];
      m_lock_dly[0] = dif.pll_locked;
      if (dif.restart) begin
        m_phase   = S_RESET;
        m_elapsed = 0;
        m_retries = 0;
      end else begin
        m_elapsed++;
        case (m_phase)
          S_RESET:
            if (m_elapsed >= P_RST) begin
              m_phase = S_WAIT; m_elapsed = 0;
            end
          S_WAIT:
            if (m_lock_seen) begin
              m_phase = S_STABLE; m_elapsed = 0;
            end else if (m_elapsed >= P_TMO) begin
              m_elapsed = 0;
              if (m_retries < P_RETRIES) begin
                m_retries++; m_phase = S_RESET;
              end else begin
                m_phase = S_FAULT;
              end
            end
          S_STABLE:
            if (!m_lock_seen) begin
              m_phase = S_WAIT; m_elapsed = 0;
            end else if (m_elapsed >= P_STABLE) begin
              m_phase = S_RUN; m_elapsed = 0; m_retries = 0;
            end
          S_RUN:
            if (!m_lock_seen) begin
              m_phase = S_RESET; m_elapsed = 0;
            end
          default: ;
        endcase
      end
    end
  end

  // Per-cycle scoreboard on the falling edge, away from the active edge
  always @(negedge refclk) begin
    check_val("state",       int'(dif.state),       m_phase);
    check_val("pll_rst",     int'(dif.pll_rst),     int'(m_phase == S_RESET || m_phase == S_FAULT));
    check_val("video_rst_n", int'(dif.video_rst_n), int'(m_phase == S_RUN));
    check_val("ready",       int'(dif.ready),       int'(m_phase == S_RUN));
    check_val("fault",       int'(dif.fault),       int'(m_phase == S_FAULT));
    check_val("retry_cnt",   int'(dif.retry_cnt),   m_retries);
    check_val("vrn_outside_run", int'(dif.video_rst_n && (dif.state != 3'd3)), 0);
  end

  task automatic wait_state(input int code, input int budget);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(negedge refclk);
      if (int'(dif.state) == code) hit = 1'b1;
    end
    check_val($sformatf("reach_state_%0d", code), int'(dif.state), code);
  endtask

  task automatic pulse_restart();
    @(negedge refclk);
    dif.restart = 1'b1;
    @(negedge refclk);
    dif.restart = 1'b0;
  endtask

  int stable_at, ready_at, vrn_drop_at, rst_len, fault_at;

  initial begin
    dif.pll_locked = 1'b0;
    dif.restart    = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(negedge refclk);
    check_val("rst_pll_rst", int'(dif.pll_rst), 1);
    check_val("rst_state",   int'(dif.state),   S_RESET);
    rst_n = 1'b1;

    // Nominal bring-up: lock at cycle 20
    repeat (20) @(negedge refclk);
    dif.pll_locked = 1'b1;
    stable_at = -1; ready_at = -1;
    for (int k = 1; k <= 30 && ready_at < 0; k++) begin
      @(negedge refclk);
      if (stable_at < 0 && dif.state == 3'd2) stable_at = k;
      if (dif.ready) ready_at = k;
    end
    check_val("bringup_stable_at", stable_at, 3);
    check_val("bringup_ready_at",  ready_at,  3 + P_STABLE);
    $display("bringup: stable_at=%0d ready_at=%0d", stable_at, ready_at);

    // Lock loss in RUN: release drop within 3 cycles, 4-cycle PLL reset pulse
    dif.pll_locked = 1'b0;
    vrn_drop_at = -1;
    for (int k = 1; k <= 10 && vrn_drop_at < 0; k++) begin
      @(negedge refclk);
      if (!dif.video_rst_n) vrn_drop_at = k;
    end
    check_val("lockloss_latency", vrn_drop_at, 3);
    rst_len = 0;
    for (int k = 0; k < 20 && dif.pll_rst; k++) begin
      rst_len++;
      @(negedge refclk);
    end
    check_val("lockloss_rst_len", rst_len, P_RST);
    $display("lockloss: vrn_drop_at=%0d pll_rst_len=%0d", vrn_drop_at, rst_len);

    // Lock chatter in STABLE at count 5: full window needed again
    dif.pll_locked = 1'b1;
    wait_state(S_STABLE, 20);
    repeat (5) @(negedge refclk);
    dif.pll_locked = 1'b0;
    @(negedge refclk);
    dif.pll_locked = 1'b1;
    ready_at = -1;
    for (int k = 1; k <= 30 && ready_at < 0; k++) begin
      @(negedge refclk);
      if (dif.ready) ready_at = k;
    end
    check_val("chatter_ready_at", ready_at, 3 + P_STABLE);
    $display("chatter: ready_at=%0d", ready_at);

    // Timeout/fault: two retries, third timeout faults
    dif.pll_locked = 1'b0;
    fault_at = -1;
    for (int k = 1; k <= 400 && fault_at < 0; k++) begin
      @(negedge refclk);
      if (dif.fault) fault_at = k;
    end
    check_val("fault_at", fault_at, 3 + (P_RETRIES + 1) * (P_RST + P_TMO));
    check_val("fault_state", int'(dif.state), S_FAULT);
    check_val("fault_retry", int'(dif.retry_cnt), P_RETRIES);
    dif.pll_locked = 1'b1;
    repeat (30) @(negedge refclk);
    check_val("fault_sticky", int'(dif.fault), 1);
    $display("timeout: fault_at=%0d retry_cnt=%0d", fault_at, dif.retry_cnt);

    // Restart in FAULT
    pulse_restart();
    check_val("restart_fault_state", int'(dif.state), S_RESET);
    check_val("restart_fault_retry", int'(dif.retry_cnt), 0);
    wait_state(S_RUN, 40);
    $display("restart from fault: state=%0d", dif.state);

    // Restart on the same edge as a RUN lock loss
    dif.pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    dif.restart = 1'b1;
    @(negedge refclk);
    dif.restart = 1'b0;
    check_val("collide_state", int'(dif.state), S_RESET);
    check_val("collide_vrn",   int'(dif.video_rst_n), 0);
    dif.pll_locked = 1'b1;
    wait_state(S_RUN, 40);
    check_val("relock_retry", int'(dif.retry_cnt), 0);
    $display("restart collision: relocked state=%0d", dif.state);

    // Random lock activity with occasional restarts
    for (int it = 0; it < 40; it++) begin
      int hold;
      hold = $urandom_range(90, 1);
      dif.pll_locked = ($urandom_range(3, 0) != 0) ? ~dif.pll_locked : dif.pll_locked;
      for (int c = 0; c < hold; c++) begin
        @(negedge refclk);
        dif.restart = ($urandom_range(63, 0) == 0);
      end
      @(negedge refclk);
      dif.restart = 1'b0;
      $display("random step %0d: hold=%0d locked=%0d state=%0d", it, hold, dif.pll_locked, dif.state);
    end

    // Asynchronous reset mid-STABLE
    dif.pll_locked = 1'b1;
    pulse_restart();
    wait_state(S_STABLE, 40);
    repeat (3) @(negedge refclk);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_pll_rst", int'(dif.pll_rst),     1);
    check_val("async_vrn",     int'(dif.video_rst_n), 0);
    check_val("async_ready",   int'(dif.ready),       0);
    check_val("async_retry",   int'(dif.retry_cnt),   0);
    check_val("async_state",   int'(dif.state),       S_RESET);
    @(negedge refclk);
    rst_n = 1'b1;
    wait_state(S_RUN, 40);
    $display("async reset: recovered state=%0d", dif.state);

    repeat (2) @(negedge refclk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
